// File: rtl/mux_2_if.sv
// Signal bundle for mux_2: four data inputs, select, capture enable and
// every combinational and registered result, with master/slave views.
interface mux_2_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [1:0]       sel;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       sel_q;
  logic [3:0]       sel_onehot;
  logic             vld_q;

  // en is a one-sided capture strobe: the master raises it and the slave
  // samples on the next rising clk. There is no ready/backpressure.
  modport master (
    output in0, in1, in2, in3, sel, en,
    input  y, y_q, sel_q, sel_onehot, vld_q
  );

  modport slave (
    input  in0, in1, in2, in3, sel, en,
    output y, y_q, sel_q, sel_onehot, vld_q
  );
endinterface

// File: rtl/mux_2.sv
// Four-way WIDTH-bit multiplexer with a combinational result, a one-hot
// select decode, and an enable-gated registered copy of result and select.
module mux_2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       sel_q,
  output logic [3:0]       sel_onehot,
  output logic             vld_q
);

  // A sel carrying X/Z matches no binary item, so both outputs fall to zero.
  always_comb begin
    y          = '0;
    sel_onehot = 4'b0000;
    case (sel)
      2'b00: begin
        y          = in0;
        sel_onehot = 4'b0001;
      end
      2'b01: begin
        y          = in1;
        sel_onehot = 4'b0010;
      end
      2'b10: begin
        y          = in2;
        sel_onehot = 4'b0100;
      end
      2'b11: begin
        y          = in3;
        sel_onehot = 4'b1000;
      end
      default: begin
        y          = '0;
        sel_onehot = 4'b0000;
      end
    endcase
  end

  // Reset is asynchronous and takes priority over a simultaneous capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      y_q   <= '0;
      sel_q <= 2'b00;
      vld_q <= 1'b0;
    end else if (en) begin
      y_q   <= y;
      sel_q <= sel;
      vld_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_2.sv
// Directed and randomized checks of mux_2 at WIDTH=8 plus a WIDTH=32
// instance, compared against an array-indexed reference model.
module tb_mux_2;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  mux_2_if #(.WIDTH(8))  bus ();
  mux_2_if #(.WIDTH(32)) bus32 ();

  mux_2 #(.WIDTH(8)) dut (
    .in0(bus.in0), .in1(bus.in1), .in2(bus.in2), .in3(bus.in3),
    .sel(bus.sel), .y(bus.y), .clk(clk), .clr(clr), .en(bus.en),
    .y_q(bus.y_q), .sel_q(bus.sel_q), .sel_onehot(bus.sel_onehot),
    .vld_q(bus.vld_q)
  );

  mux_2 #(.WIDTH(32)) dut32 (
    .in0(bus32.in0), .in1(bus32.in1), .in2(bus32.in2), .in3(bus32.in3),
    .sel(bus32.sel), .y(bus32.y), .clk(clk), .clr(clr), .en(bus32.en),
    .y_q(bus32.y_q), .sel_q(bus32.sel_q), .sel_onehot(bus32.sel_onehot),
    .vld_q(bus32.vld_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] din[4];
  logic [7:0] m_yq;
  logic [1:0] m_selq;
  logic       m_vld;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] ref_y(input logic [1:0] s);
    if ($isunknown(s)) return 8'h00;
    return din[s];
  endfunction

  function automatic logic [3:0] ref_onehot(input logic [1:0] s);
    if ($isunknown(s)) return 4'b0000;
    return 4'(1 << s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.in0 = din[0];
    bus.in1 = din[1];
    bus.in2 = din[2];
    bus.in3 = din[3];
  endtask

  task automatic model_clear();
    m_yq   = 8'h00;
    m_selq = 2'b00;
    m_vld  = 1'b0;
    exp_q.delete();
  endtask

  // One rising edge; the model decides the capture from pre-edge inputs.
  task automatic tick();
    logic       cap;
    logic [7:0] cy;
    logic [1:0] cs;
    cap = bus.en;
    cy  = ref_y(bus.sel);
    cs  = bus.sel;
    @(posedge clk);
    if (clr) model_clear();
    else if (cap) begin
      m_yq   = cy;
      m_selq = cs;
      m_vld  = 1'b1;
      exp_q.push_back(cy);
    end
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_y_q"},   32'(bus.y_q),   32'(m_yq));
    chk({tag, "_sel_q"}, 32'(bus.sel_q), 32'(m_selq));
    chk({tag, "_vld_q"}, 32'(bus.vld_q), 32'(m_vld));
  endtask

  initial begin
    logic [1:0] s;
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    bus.en = 1'b0;
    bus.sel = 2'b00;
    bus32.en = 1'b0;
    bus32.sel = 2'b00;
    bus32.in0 = '0; bus32.in1 = '0; bus32.in2 = '0; bus32.in3 = '0;
    for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
    apply();
    model_clear();

    // reset state before any clock edge
    #2;
    chk("rst_y_q",   32'(bus.y_q),   32'h0);
    chk("rst_sel_q", 32'(bus.sel_q), 32'h0);
    chk("rst_vld_q", 32'(bus.vld_q), 32'h0);

    // combinational sweep while still in reset
    din[0] = 8'h00; din[1] = 8'hA5; din[2] = 8'h3C; din[3] = 8'h00;
    apply();
    for (int k = 0; k < 4; k++) begin
      bus.sel = 2'(k);
      #0.5;
      chk($sformatf("sweep_y_%0d", k), 32'(bus.y), 32'(ref_y(2'(k))));
      chk($sformatf("sweep_oh_%0d", k), 32'(bus.sel_onehot), 32'(ref_onehot(2'(k))));
    end
    chk("sweep_a5", 32'(ref_y(2'd1)), 32'h000000A5);

    // first capture after reset release
    @(negedge clk);
    clr = 1'b0;
    bus.en = 1'b1;
    bus.sel = 2'd2;
    tick();
    chk("cap_y_q",   32'(bus.y_q),   32'h3C);
    chk("cap_sel_q", 32'(bus.sel_q), 32'h2);
    chk("cap_vld_q", 32'(bus.vld_q), 32'h1);

    // hold with en low while inputs move
    bus.en = 1'b0;
    bus.sel = 2'd1;
    din[1] = 8'hFF;
    apply();
    #1;
    chk("hold_y", 32'(bus.y), 32'hFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_y_q_%0d", k), 32'(bus.y_q), 32'h3C);
      chk_regs($sformatf("hold_%0d", k));
    end

    // asynchronous clear between edges, then normal capture
    bus.en = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    model_clear();
    chk("aclr_y_q", 32'(bus.y_q), 32'h0);
    chk_regs("aclr");
    chk("aclr_comb_y", 32'(bus.y), 32'hFF);
    clr = 1'b0;
    tick();
    chk("post_clr_y_q", 32'(bus.y_q), 32'hFF);
    chk_regs("post_clr");

    // non-binary select
    bus.sel = 2'bxx;
    #1;
    chk("selx_y",  32'(bus.y),          32'(ref_y(bus.sel)));
    chk("selx_oh", 32'(bus.sel_onehot), 32'(ref_onehot(bus.sel)));
    bus.sel = 2'd0;

    // clear held across an enabled edge: reset wins
    @(negedge clk);
    clr = 1'b1;
    tick();
    chk("coinc_y_q",  32'(bus.y_q),  32'h0);
    chk("coinc_vld",  32'(bus.vld_q), 32'h0);
    chk_regs("coinc");
    @(negedge clk);
    clr = 1'b0;

    // randomized traffic with occasional mid-cycle clears
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
      apply();
      s = 2'($urandom_range(0, 3));
      bus.sel = s;
      bus.en = ($urandom_range(0, 3) != 0);
      #1;
      chk($sformatf("rnd_y_%0d", it),  32'(bus.y),          32'(ref_y(s)));
      chk($sformatf("rnd_oh_%0d", it), 32'(bus.sel_onehot), 32'(ref_onehot(s)));
      tick();
      chk_regs($sformatf("rnd_%0d", it));
      if (exp_q.size() != 0)
        chk($sformatf("rnd_hist_%0d", it), 32'(bus.y_q), 32'(exp_q[$]));
      if ($urandom_range(0, 9) == 0) begin
        #1;
        clr = 1'b1;
        #1;
        model_clear();
        chk_regs($sformatf("rnd_clr_%0d", it));
        clr = 1'b0;
      end
    end

    // WIDTH=32 instance
    bus32.in3 = 32'hDEADBEEF;
    bus32.sel = 2'd3;
    bus32.en  = 1'b1;
    #1;
    chk("w32_y", bus32.y, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    chk("w32_y_q",   bus32.y_q,          32'hDEADBEEF);
    chk("w32_sel_q", 32'(bus32.sel_q),   32'h3);
    chk("w32_vld_q", 32'(bus32.vld_q),   32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
